box7_filter_engine: RTL

- Sweep controller and arithmetic stage directly downstream of the original-image DRAM.
- Issues one window read per cycle, each fetching a 7x7 window of 8-bit pixels as one 392-bit word.
- Computes the 7x7 box mean of each window and writes it to the filtered-image DRAM at the window-centre address.
- One start/done handshake per frame.

---
 rtl/box7_filter_if.sv | 29 ++
 rtl/box7_filter_engine.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/box7_filter_if.sv
// box7_filter_if: frame handshake plus source-window read and
// filtered-pixel write ports of the 7x7 box filter engine.
interface box7_filter_if #(
  parameter int A_WIDTH = 21,
  parameter int D_WIDTH = 8,
  parameter int MASKLEN = 392
);
  logic               start;
  logic               busy;
  logic               done;
  logic               ren;
  logic [A_WIDTH-1:0] raddr;
  logic [MASKLEN-1:0] rdata;
  logic               wen;
  logic [A_WIDTH-1:0] waddr;
  logic [D_WIDTH-1:0] wdata;

  modport master (
    input  start, rdata,
    output busy, done, ren, raddr,
    output wen, waddr, wdata
  );

  modport slave (
    output start, rdata,
    input  busy, done, ren, raddr,
    input  wen, waddr, wdata
  );
endinterface

// File: rtl/box7_filter_engine.sv
// box7_filter_engine: raster sweep of 7x7 windows over the source image,
// writing each window's box mean to the filtered image at its centre.
module box7_filter_engine #(
  parameter int IMG_W   = 1280,
  parameter int IMG_H   = 720,
  parameter int K       = 7,
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 21,
  parameter int MASKLEN = 392,
  parameter int RECIP   = 1338,
  parameter int SHIFT   = 16
) (
  input logic          clk,
  input logic          rst,
  box7_filter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int RSW = 11;
  localparam int SW  = 14;
  localparam int PW  = 25;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - K);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - K);
  localparam logic [A_WIDTH-1:0] CTR_OFS =
    A_WIDTH'((K / 2) * IMG_W + K / 2);

  state_e             state_q;
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  logic [1:0]         drain_q;
  logic               busy_q;
  logic               done_q;
  logic               ren_q;
  logic [A_WIDTH-1:0] raddr_q;

  logic               v1_q, v2_q, v3_q;
  logic [A_WIDTH-1:0] a1_q, a2_q, a3_q;
  logic [K-1:0][RSW-1:0] rsum_q, rsum_d;
  logic [SW-1:0]      sum_q, sum_d;
  logic [PW-1:0]      prod;
  logic [D_WIDTH-1:0] wdata_d;
  logic               wen_q;
  logic [A_WIDTH-1:0] waddr_q;
  logic [D_WIDTH-1:0] wdata_q;

  always_comb begin
    rsum_d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        rsum_d[r] = rsum_d[r] + RSW'(bus.rdata[
          MASKLEN - 1 - D_WIDTH * (r * K + c) -: D_WIDTH]);
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int r = 0; r < K; r++) begin
      sum_d = sum_d + SW'(rsum_q[r]);
    end
  end

  // Mean via reciprocal multiply; exact for uniform windows 0..255
  assign prod    = PW'(sum_q) * PW'(RECIP);
  assign wdata_d = D_WIDTH'(prod >> SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            ren_q   <= 1'b1;
            raddr_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        RUN: begin
          if (col_q == COL_LAST) begin
            col_q   <= '0;
            row_q   <= row_q + RW'(1);
            raddr_q <= raddr_q + A_WIDTH'(K);
          end else begin
            col_q   <= col_q + CW'(1);
            raddr_q <= raddr_q + A_WIDTH'(1);
          end
          if (col_q == COL_LAST && row_q == ROW_LAST) begin
            state_q <= DRAIN;
            ren_q   <= 1'b0;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          drain_q <= drain_q + 2'd1;
          if (drain_q == 2'd3) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      rsum_q  <= '0;
      sum_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      v1_q  <= ren_q;
      a1_q  <= raddr_q;
      v2_q  <= v1_q;
      a2_q  <= a1_q;
      v3_q  <= v2_q;
      a3_q  <= a2_q;
      wen_q <= v3_q;
      if (v1_q) rsum_q <= rsum_d;
      if (v2_q) sum_q <= sum_d;
      if (v3_q) begin
        waddr_q <= a3_q + CTR_OFS;
        wdata_q <= wdata_d;
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ren   = ren_q;
  assign bus.raddr = raddr_q;
  assign bus.wen   = wen_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;

endmodule
